// File: rtl/draw_circle_array.sv
// Multi-object filled-circle overlay stage: NUM_OBJ circles drawn in fixed priority
// (object 0 on top), positions latched at vblank, per-frame pixel overlap reporting.
module draw_circle_array #(
    parameter int unsigned           NUM_OBJ = 3,
    parameter logic [NUM_OBJ*8-1:0]  RADII   = {8'd10, 8'd20, 8'd20},
    parameter logic [NUM_OBJ*12-1:0] COLORS  = {12'habc, 12'hfff, 12'hfff}
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [11:0]             hcount_in,
    input  logic [11:0]             vcount_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    hblnk_in,
    input  logic                    vblnk_in,
    input  logic [11:0]             rgb_in,
    input  logic [NUM_OBJ*12-1:0]   xpos_in,
    input  logic [NUM_OBJ*12-1:0]   ypos_in,
    input  logic [NUM_OBJ-1:0]      obj_en_in,
    output logic [11:0]             hcount_out,
    output logic [11:0]             vcount_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    hblnk_out,
    output logic                    vblnk_out,
    output logic [11:0]             rgb_out,
    output logic [NUM_OBJ-1:0]      collide_out,
    output logic                    collide_valid,
    output logic                    frame_tick
);

    // Bundle layout: {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
    localparam int unsigned BW = 40;

    logic [BW-1:0]           bundle_in, s1_q, s2_q;
    logic                    vblnk_q, seen_edge_q, vblnk_rise;
    logic [NUM_OBJ*12-1:0]   x_sh_q, y_sh_q;
    logic [NUM_OBJ-1:0]      en_sh_q;
    logic [NUM_OBJ-1:0]      acc_q;

    logic [7:0]              dx_q [NUM_OBJ];
    logic [7:0]              dy_q [NUM_OBJ];
    logic [NUM_OBJ-1:0]      bound_q, inside_q;

    logic [7:0]              dx_d [NUM_OBJ];
    logic [7:0]              dy_d [NUM_OBJ];
    logic [NUM_OBJ-1:0]      bound_d, inside_d, hit_d;
    logic [11:0]             rgb_sel;

    assign bundle_in  = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
    assign vblnk_rise = vblnk_in & ~vblnk_q;

    // S1: distances and bounding-box test against the shadowed positions
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            logic [12:0] h, v, x, y, dx, dy, r;
            h  = {1'b0, hcount_in};
            v  = {1'b0, vcount_in};
            x  = {1'b0, x_sh_q[i*12 +: 12]};
            y  = {1'b0, y_sh_q[i*12 +: 12]};
            r  = {5'd0, RADII[i*8 +: 8]};
            dx = (h >= x) ? h - x : x - h;
            dy = (v >= y) ? v - y : y - v;
            dx_d[i]    = dx[7:0];
            dy_d[i]    = dy[7:0];
            bound_d[i] = en_sh_q[i] && (dx <= r) && (dy <= r);
        end
    end

    // S2: exact circle test (low bytes suffice once the bounding test passed) and overlap
    always_comb begin
        logic [NUM_OBJ-1:0] others;
        logic               visible;
        visible = ~s1_q[13] & ~s1_q[12];
        for (int i = 0; i < NUM_OBJ; i++) begin
            logic [15:0] dx2, dy2, r2;
            dx2 = {8'd0, dx_q[i]} * {8'd0, dx_q[i]};
            dy2 = {8'd0, dy_q[i]} * {8'd0, dy_q[i]};
            r2  = {8'd0, RADII[i*8 +: 8]} * {8'd0, RADII[i*8 +: 8]};
            inside_d[i] = visible && bound_q[i] &&
                          (({1'b0, dx2} + {1'b0, dy2}) <= {1'b0, r2});
        end
        for (int i = 0; i < NUM_OBJ; i++) begin
            others    = inside_d;
            others[i] = 1'b0;
            hit_d[i]  = inside_d[i] & (|others);
        end
    end

    // S3 select: walk from lowest priority up so object 0 overrides the rest
    always_comb begin
        rgb_sel = s2_q[11:0];
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (inside_q[i]) rgb_sel = COLORS[i*12 +: 12];
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            vblnk_q       <= 1'b0;
            seen_edge_q   <= 1'b0;
            x_sh_q        <= '0;
            y_sh_q        <= '0;
            en_sh_q       <= '0;
            acc_q         <= '0;
            collide_out   <= '0;
            collide_valid <= 1'b0;
            frame_tick    <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
            bound_q       <= '0;
            inside_q      <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
            hcount_out    <= '0;
            vcount_out    <= '0;
            hsync_out     <= 1'b0;
            vsync_out     <= 1'b0;
            hblnk_out     <= 1'b0;
            vblnk_out     <= 1'b0;
            rgb_out       <= '0;
        end else begin
            vblnk_q    <= vblnk_in;
            frame_tick <= vblnk_rise;
            if (vblnk_rise) begin
                x_sh_q      <= xpos_in;
                y_sh_q      <= ypos_in;
                en_sh_q     <= obj_en_in;
                collide_out <= acc_q;
                acc_q       <= '0;
                seen_edge_q <= 1'b1;
                // The first published frame after reset is partial
                if (seen_edge_q) collide_valid <= 1'b1;
            end else begin
                acc_q <= acc_q | hit_d;
            end

            s1_q    <= bundle_in;
            bound_q <= bound_d;
            for (int i = 0; i < NUM_OBJ; i++) begin
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
            end

            s2_q     <= s1_q;
            inside_q <= inside_d;

            {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= s2_q[39:12];
            rgb_out <= rgb_sel;
        end
    end

endmodule

// File: doc/draw_circle_array.md
# draw_circle_array

Parametrised multi-object drawing stage for the VGA pixel pipeline. It replaces chained single-circle stages with one block that overlays NUM_OBJ filled circles (players, puck, markers) in fixed priority. Object positions are latched once per frame at vblank, and pixel-level overlap between objects is reported per frame. It sits between the background stage and the output registers and passes through the same hcount/vcount/sync/blank bundle.

## Interface
Parameters:
- NUM_OBJ, 3, number of circles; 1..8
- RADII, {8'd10, 8'd20, 8'd20}, packed NUM_OBJ×8; object i radius in bits [8i+7:8i], 1..255
- COLORS, {12'habc, 12'hfff, 12'hfff}, packed NUM_OBJ×12; object i colour in bits [12i+11:12i]

Ports:
- clk_in  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- hcount_in, vcount_in  in  12 each  pixel counters
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing signals
- rgb_in  in  12  upstream pixel
- xpos_in, ypos_in  in  NUM_OBJ×12 each  object centres, object i in bits [12i+11:12i]
- obj_en_in  in  NUM_OBJ  per-object draw enable
- hcount_out, vcount_out  out  12 each  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing signals
- rgb_out  out  12  composited pixel
- collide_out  out  NUM_OBJ  bit i: object i overlapped another enabled object in the previous frame
- collide_valid  out  1  collide_out holds a complete frame
- frame_tick  out  1  one-cycle pulse on each vblank rising edge

## Operation
- Frame latch: vblnk_in is registered. On a 0→1 edge (vblnk_in=1, previous=0), xpos_in, ypos_in and obj_en_in are captured into shadow registers. The shadow registers alone drive drawing, so mid-frame input changes do not tear the image.
- Same edge: collide_out ← accumulator, accumulator ← 0, frame_tick = 1.
- collide_valid: 0 after reset. Set at the second vblank edge after reset, because the first published frame is partial. Stays set until reset.
- Inside test for object i, pixel (h,v), all unsigned: dx=|h−x_i|, dy=|v−y_i| (13-bit). Inside iff en_i & dx≤R_i & dy≤R_i & dx²+dy²≤R_i². The square terms use only the low 8 bits (valid under the bounding test); the sum is 17 bits and R_i² is 16 bits.
- Compositing outside blanking (hblnk=0 and vblnk=0): the lowest-index inside object wins (object 0 on top). If no object is inside, rgb_in is passed through.
- During blanking: rgb_in passes through, no objects are drawn, and no collisions accumulate.
- Collision accumulation: for each visible pixel, if object i is inside and at least one other object j≠i is inside, accumulator bit i is set (sticky until the next vblank edge).
- Edge cases:
  - A circle that partly exceeds the screen is clipped naturally.
  - x_i<R_i needs no special handling (absolute difference).
  - Disabled objects never draw or collide.
  - A single object (NUM_OBJ=1) gives collide_out ≡ 0.

## Timing
- Pipeline latency is fixed at 3 clk_in cycles from every *_in pixel/timing input to the matching *_out.
  - S1: registered dx, dy and bounding flags.
  - S2: registered inside flags and collision update.
  - S3: registered priority mux.
- Timing signals and counters are delayed through 3 matching registers.
- frame_tick and the collide_out update occur 1 cycle after the vblnk_in rising edge is sampled. They are not aligned to vblnk_out.
- Shadow registers take effect on the first S1 computation after the latch cycle.
- Reset (asynchronous, any time, including mid-frame): all outputs, pipeline registers, shadow registers, accumulator, collide_out, collide_valid, frame_tick and the vblank edge register are cleared to 0. Objects are therefore disabled until the first vblank edge after reset.

## Test plan
- Single object: NUM_OBJ=1, R=20, centre (100,100), enabled, rgb_in=12'h0f0. Pixel (120,100) → 12'hfff. Pixel (115,115) (450>400) → 12'h0f0. Output appears exactly 3 cycles after input.
- Priority: obj0 R=10 colour abc and obj1 R=20 colour fff, both at (200,200). Pixel (205,200) → 12'habc. Pixel (215,200) → 12'hfff.
- Frame latch: change xpos_in mid-frame. Drawn position is unchanged until after the next vblnk_in rising edge, and frame_tick pulses exactly once per frame.
- Collision: obj0 (300,300) R=10, obj1 (315,300) R=10. After the frame, collide_out=2'b11. Move obj1 to (400,300): collide_out=2'b00 one frame later. Disabling obj1 also gives 2'b00.
- Blanking: an object centred at (0,0) during hblnk=1 → rgb_out=rgb_in and no collision bits are set.
- Reset: assert rst mid-frame. All outputs read 0 immediately. collide_valid=0 after the first vblank edge and 1 after the second.
